uc_seq: RTL and testbench
=========================

// Module: uc_seq
// PURPOSE
//  Multi-cycle control unit for the microc datapath. Decodes the 6-bit Opcode and the z flag.
//  Drives s_inc, s_inm, we3, wez, Op and a PC enable.
//  Runs a FETCH/EXEC sequence so that instruction-memory latency and halting are handled here.
//  Sits beside microc in the top level; replaces hand-driven control from the bench.
// PARAMETERS
//  FETCH_CYCLES  1   cycles spent in FETCH per instruction (imem latency), legal 1..15
//  CNT_W         16  width of retired-instruction counter
// PORTS
//  clk        in   1      system clock, rising edge
//  reset      in   1      synchronous, active-high reset
//  run        in   1      level; leaving IDLE requires run=1
//  Opcode     in   6      instruction opcode from microc
//  z          in   1      registered zero flag from microc
//  s_inc      out  1      PC mux select: 1=PC+1, 0=jump target
//  s_inm      out  1      regfile write mux: 1=immediate, 0=ALU
//  we3        out  1      regfile write enable
//  wez        out  1      zero-flag write enable
//  Op         out  3      ALU operation
//  pc_en      out  1      PC register load enable
//  halted     out  1      1 while in HALT
//  illegal    out  1      sticky: undefined opcode executed
//  instr_cnt  out  CNT_W  retired instructions, wraps modulo 2^CNT_W
// BEHAVIOUR
//  - FSM states: IDLE -> FETCH -> EXEC -> FETCH ...; EXEC of HALT -> HALT.
//  - IDLE -> FETCH when run=1. FETCH holds FETCH_CYCLES cycles (down-counter), then EXEC.
//  - EXEC lasts exactly 1 cycle. HALT is left only by reset.
//  - reset (sync): state=IDLE, fetch counter=FETCH_CYCLES-1, illegal=0, instr_cnt=0.
//  - Outputs outside EXEC (incl. reset cycle): s_inc=1, s_inm=0, we3=0, wez=0, Op=000, pc_en=0.
//  - In EXEC, pc_en=1 and outputs are combinational from Opcode and z:
//      1ooo_xx  ALU reg-reg:  Op=Opcode[4:2], s_inm=0, we3=1, wez=1, s_inc=1
//      0000_xx  LI:           Op=000, s_inm=1, we3=1, wez=0, s_inc=1
//      0001_xx  ADI:          Op=010, s_inm=1, we3=1, wez=1, s_inc=1
//      0010_xx  SBI:          Op=011, s_inm=1, we3=1, wez=1, s_inc=1
//      010000   J:            s_inc=0, no writes
//      010001   JZ:           s_inc=~z, no writes
//      010010   JNZ:          s_inc=z, no writes
//      011111   HALT:         pc_en=0, no writes, next state HALT
//      other    illegal:      executes as NOP (pc_en=1, s_inc=1, no writes); illegal<=1
//  - z is sampled in the EXEC cycle itself. A flag written by the previous EXEC is already valid.
//  - instr_cnt increments on each EXEC cycle, except HALT. Wraps from all-ones to 0.
//  - halted=1 from the cycle after HALT's EXEC until reset.
//  - run deasserted mid-program has no effect. run is sampled only in IDLE.
//  - reset asserted in any state: the next edge forces IDLE. Writes are suppressed in that cycle.
// CONFIGURATION
//  UC_SEQ_STEP_EN defined:
//   - adds input `step` (1 bit).
//   - FETCH->EXEC additionally requires step=1 once the fetch counter expires.
//   - the state waits in FETCH with outputs idle until step=1.
//   - one EXEC per step cycle where step is high.
//  UC_SEQ_STEP_EN undefined: no step port; FETCH->EXEC on counter expiry only.
// STRUCTURE
//  - Shared package microc_pkg (include microc_pkg.vh) holds:
//      ALU op codes: OP_PASS=000, OP_ADD=010, OP_SUB=011, OP_AND=100.
//      Opcode constants and patterns.
//      FSM state encodings IDLE/FETCH/EXEC/HALT.
//  - Sub-module uc_decode: purely combinational decode.
//      In: Opcode, z. Out: raw control bundle plus is_halt, is_illegal.
//  - uc_seq: FSM, fetch counter, gating, illegal flag, instr_cnt.
// TESTING
//  - Reset: reset=1 for 2 cycles, run=0.
//      -> IDLE, all EXEC controls idle, pc_en=0, instr_cnt=0, illegal=0.
//  - FETCH_CYCLES=1, run=1, Opcode=000000 (LI).
//      -> pc_en pulses every 2nd cycle; in EXEC s_inm=1, we3=1, wez=0, Op=000.
//      -> instr_cnt=1 after the first EXEC.
//  - Opcode=101100 (reg ALU, Op=011).
//      -> EXEC: Op=011, we3=1, wez=1, s_inm=0, s_inc=1.
//  - JZ (010001) with z=1 -> s_inc=0. JZ with z=0 -> s_inc=1.
//  - JNZ (010010) with z=1 -> s_inc=1. Both cases: we3=wez=0.
//  - Opcode=011111 -> pc_en=0 in EXEC, halted=1 next cycle, held 20 cycles with run toggling.
//  - Opcode=010111 -> illegal=1 sticky, NOP executed.
//  - Reset mid-FETCH with FETCH_CYCLES=3 -> IDLE next edge, illegal cleared.
//  - With UC_SEQ_STEP_EN: step=0 holds FETCH 10 cycles; a 1-cycle step pulse -> exactly one EXEC.

Source files
------------

// File: rtl/microc_pkg.sv
// ============================================================================
// Module   : microc_pkg
// Brief    : Shared constants, opcode patterns, control bundle and FSM
//            encodings for the microc control unit.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package microc_pkg;

  // ALU operation codes
  localparam logic [2:0] OP_PASS = 3'b000;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_SUB  = 3'b011;
  localparam logic [2:0] OP_AND  = 3'b100;

  // Immediate-class opcodes are matched on Opcode[5:2]
  localparam logic [3:0] c_OPC4_LI  = 4'b0000;
  localparam logic [3:0] c_OPC4_ADI = 4'b0001;
  localparam logic [3:0] c_OPC4_SBI = 4'b0010;

  // Control-flow opcodes are matched on the full 6 bits
  localparam logic [5:0] c_OPC_J    = 6'b010000;
  localparam logic [5:0] c_OPC_JZ   = 6'b010001;
  localparam logic [5:0] c_OPC_JNZ  = 6'b010010;
  localparam logic [5:0] c_OPC_HALT = 6'b011111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_EXEC  = 2'd2,
    ST_HALT  = 2'd3
  } state_e;

  typedef struct packed {
    logic       s_inc;
    logic       s_inm;
    logic       we3;
    logic       wez;
    logic [2:0] op;
  } ctrl_t;

  // Safe control word: fall through to PC+1, no register or flag writes
  localparam ctrl_t c_CTRL_IDLE = '{s_inc: 1'b1, s_inm: 1'b0, we3: 1'b0,
                                    wez: 1'b0, op: OP_PASS};

endpackage : microc_pkg

`default_nettype wire

// File: rtl/uc_decode.sv
// ============================================================================
// Module   : uc_decode
// Brief    : Purely combinational opcode/z-flag decode into a raw control
//            bundle plus HALT and illegal-opcode indications.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uc_decode
  import microc_pkg::*;
(
  input  logic [5:0] opcode_i,
  input  logic       z_i,
  output ctrl_t      ctrl_o,
  output logic       is_halt_o,
  output logic       is_illegal_o
);

  always_comb begin
    ctrl_o       = c_CTRL_IDLE;
    is_halt_o    = 1'b0;
    is_illegal_o = 1'b0;

    if (opcode_i[5]) begin
      ctrl_o.op  = opcode_i[4:2];
      ctrl_o.we3 = 1'b1;
      ctrl_o.wez = 1'b1;
    end else begin
      case (opcode_i[5:2])
        c_OPC4_LI: begin
          ctrl_o.s_inm = 1'b1;
          ctrl_o.we3   = 1'b1;
        end
        c_OPC4_ADI: begin
          ctrl_o.op    = OP_ADD;
          ctrl_o.s_inm = 1'b1;
          ctrl_o.we3   = 1'b1;
          ctrl_o.wez   = 1'b1;
        end
        c_OPC4_SBI: begin
          ctrl_o.op    = OP_SUB;
          ctrl_o.s_inm = 1'b1;
          ctrl_o.we3   = 1'b1;
          ctrl_o.wez   = 1'b1;
        end
        default: begin
          // Undefined encodings keep the NOP word and only raise is_illegal
          case (opcode_i)
            c_OPC_J:    ctrl_o.s_inc = 1'b0;
            c_OPC_JZ:   ctrl_o.s_inc = ~z_i;
            c_OPC_JNZ:  ctrl_o.s_inc = z_i;
            c_OPC_HALT: is_halt_o    = 1'b1;
            default:    is_illegal_o = 1'b1;
          endcase
        end
      endcase
    end
  end

endmodule : uc_decode

`default_nettype wire

// File: rtl/uc_seq.sv
// ============================================================================
// Module   : uc_seq
// Brief    : Multi-cycle IDLE/FETCH/EXEC/HALT control unit for microc.
//            Optional single-step gating via macro UC_SEQ_STEP_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uc_seq
  import microc_pkg::*;
#(
  parameter int FETCH_CYCLES = 1,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
`ifdef UC_SEQ_STEP_EN
  input  logic             step,
`endif
  input  logic [5:0]       Opcode,
  input  logic             z,
  output logic             s_inc,
  output logic             s_inm,
  output logic             we3,
  output logic             wez,
  output logic [2:0]       Op,
  output logic             pc_en,
  output logic             halted,
  output logic             illegal,
  output logic [CNT_W-1:0] instr_cnt
);

  localparam logic [3:0]       c_FETCH_RELOAD = 4'(FETCH_CYCLES - 1);
  localparam logic [CNT_W-1:0] c_CNT_ONE      = {{(CNT_W-1){1'b0}}, 1'b1};

  state_e           state_q, state_d;
  logic [3:0]       fcnt_q, fcnt_d;
  logic             illegal_q, illegal_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  ctrl_t w_dec_ctrl;
  ctrl_t w_ctrl;
  logic  w_is_halt;
  logic  w_is_illegal;
  logic  w_step_ok;

`ifdef UC_SEQ_STEP_EN
  assign w_step_ok = step;
`else
  assign w_step_ok = 1'b1;
`endif

  uc_decode u_decode (
    .opcode_i     (Opcode),
    .z_i          (z),
    .ctrl_o       (w_dec_ctrl),
    .is_halt_o    (w_is_halt),
    .is_illegal_o (w_is_illegal)
  );

  always_comb begin
    state_d   = state_q;
    fcnt_d    = fcnt_q;
    illegal_d = illegal_q;
    cnt_d     = cnt_q;
    w_ctrl    = c_CTRL_IDLE;
    pc_en     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (run) state_d = ST_FETCH;
      end
      ST_FETCH: begin
        // Counter parks at zero while waiting for a step
        if (fcnt_q == 4'd0) begin
          if (w_step_ok) begin
            state_d = ST_EXEC;
            fcnt_d  = c_FETCH_RELOAD;
          end
        end else begin
          fcnt_d = fcnt_q - 4'd1;
        end
      end
      ST_EXEC: begin
        w_ctrl = w_dec_ctrl;
        if (w_is_halt) begin
          state_d = ST_HALT;
        end else begin
          pc_en   = 1'b1;
          state_d = ST_FETCH;
          cnt_d   = cnt_q + c_CNT_ONE;
          if (w_is_illegal) illegal_d = 1'b1;
        end
      end
      default: state_d = ST_HALT;
    endcase

    // No datapath writes may escape in the cycle that reset is applied
    if (reset) begin
      w_ctrl = c_CTRL_IDLE;
      pc_en  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      fcnt_q    <= c_FETCH_RELOAD;
      illegal_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      fcnt_q    <= fcnt_d;
      illegal_q <= illegal_d;
      cnt_q     <= cnt_d;
    end
  end

  assign s_inc     = w_ctrl.s_inc;
  assign s_inm     = w_ctrl.s_inm;
  assign we3       = w_ctrl.we3;
  assign wez       = w_ctrl.wez;
  assign Op        = w_ctrl.op;
  assign halted    = (state_q == ST_HALT);
  assign illegal   = illegal_q;
  assign instr_cnt = cnt_q;

endmodule : uc_seq

`default_nettype wire

// File: tb/tb_uc_seq.sv
// ============================================================================
// Module   : tb_uc_seq
// Brief    : Self-checking bench for uc_seq; two instances (FETCH_CYCLES 1 and 3)
//            share stimulus and are checked against a cycle-timing model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uc_seq;

  localparam int FC_A = 1;
  localparam int W_A  = 4;
  localparam int FC_B = 3;
  localparam int W_B  = 16;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       run = 1'b0;
  logic [5:0] Opcode = 6'd0;
  logic       z = 1'b0;

  logic           a_s_inc, a_s_inm, a_we3, a_wez, a_pc_en, a_halted, a_illegal;
  logic [2:0]     a_Op;
  logic [W_A-1:0] a_cnt;
  logic           b_s_inc, b_s_inm, b_we3, b_wez, b_pc_en, b_halted, b_illegal;
  logic [2:0]     b_Op;
  logic [W_B-1:0] b_cnt;

  int ncmp = 0;
  int nerr = 0;

  // Model: cycles elapsed since run was taken; EXEC falls on multiples of FC+1
  bit started [2];
  int nphase  [2];
  bit m_halt  [2];
  int m_cnt   [2];
  bit m_ill   [2];
  int fc      [2];
  int wmask   [2];

  always #5 clk = ~clk;

  uc_seq #(.FETCH_CYCLES(FC_A), .CNT_W(W_A)) dut_a (
    .clk(clk), .reset(reset), .run(run),
`ifdef UC_SEQ_STEP_EN
    .step(1'b1),
`endif
    .Opcode(Opcode), .z(z),
    .s_inc(a_s_inc), .s_inm(a_s_inm), .we3(a_we3), .wez(a_wez), .Op(a_Op),
    .pc_en(a_pc_en), .halted(a_halted), .illegal(a_illegal), .instr_cnt(a_cnt)
  );

  uc_seq #(.FETCH_CYCLES(FC_B), .CNT_W(W_B)) dut_b (
    .clk(clk), .reset(reset), .run(run),
`ifdef UC_SEQ_STEP_EN
    .step(1'b1),
`endif
    .Opcode(Opcode), .z(z),
    .s_inc(b_s_inc), .s_inm(b_s_inm), .we3(b_we3), .wez(b_wez), .Op(b_Op),
    .pc_en(b_pc_en), .halted(b_halted), .illegal(b_illegal), .instr_cnt(b_cnt)
  );

  // 0 ALU, 1 LI, 2 ADI, 3 SBI, 4 J, 5 JZ, 6 JNZ, 7 HALT, 8 illegal
  function automatic int classify(input logic [5:0] o);
    int v;
    v = int'(o);
    if (v >= 32) return 0;
    if (v < 4)   return 1;
    if (v < 8)   return 2;
    if (v < 12)  return 3;
    if (v == 16) return 4;
    if (v == 17) return 5;
    if (v == 18) return 6;
    if (v == 31) return 7;
    return 8;
  endfunction

  // Packed as {s_inc, s_inm, we3, wez, Op[2:0], pc_en}
  function automatic logic [7:0] expect_ctrl(input bit ex, input logic [5:0] o, input logic zz);
    logic s_i, s_m, w3, wz, pc;
    logic [2:0] op;
    s_i = 1'b1; s_m = 1'b0; w3 = 1'b0; wz = 1'b0; op = 3'd0; pc = 1'b0;
    if (ex) begin
      pc = 1'b1;
      case (classify(o))
        0: begin op = 3'((int'(o) / 4) % 8); w3 = 1'b1; wz = 1'b1; end
        1: begin s_m = 1'b1; w3 = 1'b1; end
        2: begin op = 3'd2; s_m = 1'b1; w3 = 1'b1; wz = 1'b1; end
        3: begin op = 3'd3; s_m = 1'b1; w3 = 1'b1; wz = 1'b1; end
        4: s_i = 1'b0;
        5: s_i = ~zz;
        6: s_i = zz;
        7: pc = 1'b0;
        default: ;
      endcase
    end
    return {s_i, s_m, w3, wz, op, pc};
  endfunction

  function automatic bit in_exec(input int i);
    return started[i] && !m_halt[i] && (nphase[i] % (fc[i] + 1) == 0);
  endfunction

  task automatic chk(input string tag, input int i, input logic [31:0] got, input logic [31:0] exp);
    ncmp++;
    assert (got === exp)
    else begin
      nerr++;
      $error("FAIL %s[dut%0d] t=%0t observed=%0h expected=%0h", tag, i, $time, got, exp);
    end
  endtask

  task automatic check_all();
    logic [7:0] g;
    for (int i = 0; i < 2; i++) begin
      if (i == 0) g = {a_s_inc, a_s_inm, a_we3, a_wez, a_Op, a_pc_en};
      else        g = {b_s_inc, b_s_inm, b_we3, b_wez, b_Op, b_pc_en};
      chk("ctrl", i, 32'(g), 32'(expect_ctrl(in_exec(i) && !reset, Opcode, z)));
      chk("halted", i, 32'(i == 0 ? a_halted : b_halted), 32'(m_halt[i]));
      chk("illegal", i, 32'(i == 0 ? a_illegal : b_illegal), 32'(m_ill[i]));
      chk("instr_cnt", i, (i == 0) ? 32'(a_cnt) : 32'(b_cnt), 32'(m_cnt[i] & wmask[i]));
    end
  endtask

  task automatic update_model();
    int c;
    for (int i = 0; i < 2; i++) begin
      if (reset) begin
        started[i] = 0; nphase[i] = 0; m_halt[i] = 0; m_cnt[i] = 0; m_ill[i] = 0;
      end else if (m_halt[i]) begin
      end else if (!started[i]) begin
        if (run) begin started[i] = 1; nphase[i] = 1; end
      end else begin
        if (in_exec(i)) begin
          c = classify(Opcode);
          if (c == 7) m_halt[i] = 1;
          else begin
            m_cnt[i] = m_cnt[i] + 1;
            if (c == 8) m_ill[i] = 1;
          end
        end
        nphase[i] = nphase[i] + 1;
      end
    end
  endtask

  task automatic cyc(input bit r, input bit rn, input logic [5:0] op, input bit zz);
    reset = r; run = rn; Opcode = op; z = zz;
    @(negedge clk);
    check_all();
    @(posedge clk);
    update_model();
    #1;
  endtask

  task automatic rep(input int n, input bit rn, input logic [5:0] op, input bit zz);
    for (int k = 0; k < n; k++) cyc(1'b0, rn, op, zz);
  endtask

  initial begin
    fc[0] = FC_A; fc[1] = FC_B;
    wmask[0] = (1 << W_A) - 1; wmask[1] = (1 << W_B) - 1;
    for (int i = 0; i < 2; i++) begin
      started[i] = 0; nphase[i] = 0; m_halt[i] = 0; m_cnt[i] = 0; m_ill[i] = 0;
    end
    @(posedge clk);
    #1;

    cyc(1'b1, 1'b0, 6'b000000, 1'b0);
    cyc(1'b1, 1'b0, 6'b000000, 1'b0);
    rep(3, 1'b0, 6'b000000, 1'b0);

    rep(8, 1'b1, 6'b000000, 1'b0);
    rep(8, 1'b0, 6'b101100, 1'b0);
    rep(8, 1'b1, 6'b010001, 1'b1);
    rep(8, 1'b1, 6'b010001, 1'b0);
    rep(8, 1'b0, 6'b010010, 1'b1);
    rep(8, 1'b0, 6'b010010, 1'b0);
    rep(8, 1'b1, 6'b010000, 1'b0);
    rep(8, 1'b1, 6'b000101, 1'b0);
    rep(8, 1'b1, 6'b001010, 1'b1);
    rep(8, 1'b1, 6'b010111, 1'b0);
    rep(8, 1'b1, 6'b000000, 1'b0);

    // Reset while dut_b sits mid-FETCH, then restart
    cyc(1'b1, 1'b0, 6'b000000, 1'b0);
    rep(2, 1'b1, 6'b000000, 1'b0);
    cyc(1'b1, 1'b1, 6'b000000, 1'b0);
    rep(4, 1'b1, 6'b000000, 1'b0);

    rep(8, 1'b1, 6'b011111, 1'b0);
    for (int k = 0; k < 20; k++)
      cyc(1'b0, k[0], 6'($urandom_range(0, 63)), 1'($urandom));
    cyc(1'b1, 1'b0, 6'b000000, 1'b0);

    // Enough EXECs to wrap the 4-bit counter of dut_a
    rep(40, 1'b1, 6'b110000, 1'b0);

    for (int k = 0; k < 400; k++) begin
      logic [5:0] op;
      op = 6'($urandom_range(0, 63));
      if (op == 6'b011111 && ($urandom_range(0, 3) != 0)) op = 6'b000100;
      cyc(($urandom_range(0, 49) == 0), 1'($urandom), op, 1'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule : tb_uc_seq

`default_nettype wire
